// File: rtl/window_count_fifo_if.sv
// window_count_fifo_if: snapshot push / registered read-port bundle.
// master drives update/valid/n_*/rd_en/clr_overflow; slave drives rd_*/status.
interface window_count_fifo_if #(
   parameter int P_N_WIDTH    = 16,
   parameter int P_ADDR_WIDTH = 4
);
   logic                   update;
   logic                   valid;
   logic [P_N_WIDTH-1:0]   n_pedge;
   logic [P_N_WIDTH-1:0]   n_nedge;
   logic [P_N_WIDTH-1:0]   n_high;
   logic [P_N_WIDTH-1:0]   n_low;
   logic                   rd_en;
   logic                   clr_overflow;
   logic                   rd_valid;
   logic [P_N_WIDTH-1:0]   rd_pedge;
   logic [P_N_WIDTH-1:0]   rd_nedge;
   logic [P_N_WIDTH-1:0]   rd_high;
   logic [P_N_WIDTH-1:0]   rd_low;
   logic [P_N_WIDTH-1:0]   rd_seq;
   logic                   empty;
   logic                   full;
   logic [P_ADDR_WIDTH:0]  n_words;
   logic                   overflow;
   logic [P_N_WIDTH-1:0]   n_dropped;

   modport master (
      output update, valid,
      output n_pedge, n_nedge, n_high, n_low,
      output rd_en, clr_overflow,
      input  rd_valid,
      input  rd_pedge, rd_nedge, rd_high, rd_low,
      input  rd_seq,
      input  empty, full, n_words,
      input  overflow, n_dropped
   );

   modport slave (
      input  update, valid,
      input  n_pedge, n_nedge, n_high, n_low,
      input  rd_en, clr_overflow,
      output rd_valid,
      output rd_pedge, rd_nedge, rd_high, rd_low,
      output rd_seq,
      output empty, full, n_words,
      output overflow, n_dropped
   );
endinterface

// File: rtl/window_count_fifo.sv
// window_count_fifo: FIFO of per-window count snapshots, 1-cycle read port,
// sticky overflow and saturating drop count. Ports: clk, rst (async high),
// bus (window_count_fifo_if.slave). Define WINDOW_COUNT_FIFO_SEQ_EN to
// store a window sequence number per entry on rd_seq (else rd_seq = 0).
module window_count_fifo #(
   parameter int P_N_WIDTH    = 16,
   parameter int P_ADDR_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   window_count_fifo_if.slave     bus
);

   localparam int DEPTH = 1 << P_ADDR_WIDTH;

   typedef struct packed {
      logic [P_N_WIDTH-1:0] pedge;
      logic [P_N_WIDTH-1:0] nedge;
      logic [P_N_WIDTH-1:0] high;
      logic [P_N_WIDTH-1:0] low;
   } entry_t;

   entry_t                 mem [DEPTH];
   entry_t                 rd_q;
   logic [P_ADDR_WIDTH-1:0] wr_ptr;
   logic [P_ADDR_WIDTH-1:0] rd_ptr;
   logic [P_ADDR_WIDTH:0]   n_words_q;
   logic                   rd_valid_q;
   logic                   overflow_q;
   logic [P_N_WIDTH-1:0]   n_dropped_q;

   logic push_req;
   logic pop;
   logic push;
   logic drop;
   logic full_w;
   logic empty_w;

   // occupancy never exceeds DEPTH, so its MSB alone means full
   assign full_w   = n_words_q[P_ADDR_WIDTH];
   assign empty_w  = (n_words_q == '0);
   assign push_req = bus.update & bus.valid;
   assign pop      = bus.rd_en & ~empty_w;
   // a pop in the same cycle frees the slot the push needs
   assign push     = push_req & (~full_w | pop);
   assign drop     = push_req & full_w & ~pop;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{pedge: bus.n_pedge,
                          nedge: bus.n_nedge,
                          high:  bus.n_high,
                          low:   bus.n_low};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         n_words_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case (1'b1)
            push & ~pop: n_words_q <= n_words_q + 1'b1;
            pop & ~push: n_words_q <= n_words_q - 1'b1;
            default:     n_words_q <= n_words_q;
         endcase
      end
   end

   // head read is old-value even when a full-FIFO push hits the same slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_q       <= '0;
      end else begin
         rd_valid_q <= pop;
         if (pop) rd_q <= mem[rd_ptr];
      end
   end

   // a drop coinciding with a clear counts as the first drop after it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         n_dropped_q <= '0;
      end else if (drop) begin
         overflow_q <= 1'b1;
         if (bus.clr_overflow)
            n_dropped_q <= {{(P_N_WIDTH-1){1'b0}}, 1'b1};
         else if (~&n_dropped_q)
            n_dropped_q <= n_dropped_q + 1'b1;
      end else if (bus.clr_overflow) begin
         overflow_q  <= 1'b0;
         n_dropped_q <= '0;
      end
   end

`ifdef WINDOW_COUNT_FIFO_SEQ_EN
   logic [P_N_WIDTH-1:0] seq_mem [DEPTH];
   logic [P_N_WIDTH-1:0] seq_cnt;
   logic [P_N_WIDTH-1:0] rd_seq_q;

   always_ff @(posedge clk) begin
      if (push) seq_mem[wr_ptr] <= seq_cnt;
   end

   // counts every complete window, dropped or not, so gaps show drops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq_cnt  <= '0;
         rd_seq_q <= '0;
      end else begin
         if (push_req) seq_cnt <= seq_cnt + 1'b1;
         if (pop)      rd_seq_q <= seq_mem[rd_ptr];
      end
   end

   assign bus.rd_seq = rd_seq_q;
`else
   assign bus.rd_seq = '0;
`endif

   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_pedge  = rd_q.pedge;
   assign bus.rd_nedge  = rd_q.nedge;
   assign bus.rd_high   = rd_q.high;
   assign bus.rd_low    = rd_q.low;
   assign bus.empty     = empty_w;
   assign bus.full      = full_w;
   assign bus.n_words   = n_words_q;
   assign bus.overflow  = overflow_q;
   assign bus.n_dropped = n_dropped_q;

endmodule

// File: tb/tb_window_count_fifo.sv
// tb_window_count_fifo: directed + random stimulus against a queue model.
// Ports of DUT reached through window_count_fifo_if.
module tb_window_count_fifo;

   localparam int W     = 8;
   localparam int A     = 4;
   localparam int DEPTH = 16;
   localparam int NMAX  = 255;

   logic clk;
   logic rst;

   window_count_fifo_if #(.P_N_WIDTH(W), .P_ADDR_WIDTH(A)) bus ();

   window_count_fifo #(.P_N_WIDTH(W), .P_ADDR_WIDTH(A)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int p;
      int n;
      int h;
      int l;
      int seq;
   } ent_t;

   ent_t m_q[$];
   ent_t m_rd;
   int   m_seq;
   int   m_nd;
   bit   m_ovf;
   bit   m_rd_valid;

   int vectors;
   int miscompares;

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_rd       = '{0, 0, 0, 0, 0};
      m_seq      = 0;
      m_nd       = 0;
      m_ovf      = 1'b0;
      m_rd_valid = 1'b0;
   endtask

   // one clock of behaviour, using the inputs held across the edge
   task automatic model_edge();
      bit   rd;
      bit   pr;
      bit   clr;
      bit   was_full;
      ent_t e;
      rd       = bus.rd_en;
      pr       = bus.update && bus.valid;
      clr      = bus.clr_overflow;
      was_full = (m_q.size() == DEPTH);
      m_rd_valid = 1'b0;
      if (rd && m_q.size() > 0) begin
         m_rd       = m_q.pop_front();
         m_rd_valid = 1'b1;
      end
      if (pr) begin
         e = '{int'(bus.n_pedge), int'(bus.n_nedge),
               int'(bus.n_high), int'(bus.n_low), m_seq};
         m_seq = (m_seq + 1) % (NMAX + 1);
         if (m_q.size() < DEPTH) begin
            m_q.push_back(e);
         end else begin
            m_ovf = 1'b1;
            m_nd  = clr ? 1 : ((m_nd < NMAX) ? m_nd + 1 : NMAX);
         end
      end
      if (clr && !(pr && was_full && !m_rd_valid)) begin
         m_ovf = 1'b0;
         m_nd  = 0;
      end
   endtask

   task automatic check_all();
      int exp_seq;
`ifdef WINDOW_COUNT_FIFO_SEQ_EN
      exp_seq = m_rd.seq;
`else
      exp_seq = 0;
`endif
      check("rd_valid", int'(bus.rd_valid), int'(m_rd_valid));
      check("rd_pedge", int'(bus.rd_pedge), m_rd.p);
      check("rd_nedge", int'(bus.rd_nedge), m_rd.n);
      check("rd_high", int'(bus.rd_high), m_rd.h);
      check("rd_low", int'(bus.rd_low), m_rd.l);
      check("rd_seq", int'(bus.rd_seq), exp_seq);
      check("empty", int'(bus.empty), int'(m_q.size() == 0));
      check("full", int'(bus.full), int'(m_q.size() == DEPTH));
      check("n_words", int'(bus.n_words), m_q.size());
      check("overflow", int'(bus.overflow), int'(m_ovf));
      check("n_dropped", int'(bus.n_dropped), m_nd);
   endtask

   task automatic step_c(input bit upd, input bit vld,
                         input bit rd, input bit clr,
                         input int p, input int n,
                         input int h, input int l);
      bus.update       = upd;
      bus.valid        = vld;
      bus.rd_en        = rd;
      bus.clr_overflow = clr;
      bus.n_pedge      = W'(p);
      bus.n_nedge      = W'(n);
      bus.n_high       = W'(h);
      bus.n_low        = W'(l);
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic step(input bit upd, input bit vld,
                       input bit rd, input bit clr);
      step_c(upd, vld, rd, clr,
             int'($urandom_range(0, NMAX)), int'($urandom_range(0, NMAX)),
             int'($urandom_range(0, NMAX)), int'($urandom_range(0, NMAX)));
   endtask

   // asynchronous reset raised mid-cycle, checked before any edge
   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_all();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1;
      bus.update = 0; bus.valid = 0; bus.rd_en = 0; bus.clr_overflow = 0;
      bus.n_pedge = 0; bus.n_nedge = 0; bus.n_high = 0; bus.n_low = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // update without valid ignored, one real snapshot read back
      step(1, 0, 0, 0);
      step_c(1, 1, 0, 0, 5, 4, 100, 28);
      step(0, 0, 1, 0);
      check("tp1_pedge", int'(bus.rd_pedge), 5);
      check("tp1_low", int'(bus.rd_low), 28);
      check("tp1_empty", int'(bus.empty), 1);
      step(0, 0, 0, 0);

      // fill, overflow by 3, drain, then one more push
      do_reset();
      repeat (19) step(1, 1, 0, 0);
      check("tp2_ndrop", int'(bus.n_dropped), 3);
      repeat (16) step(0, 0, 1, 0);
      step(1, 1, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 1);

      // full plus simultaneous push/pop
      repeat (16) step(1, 1, 0, 0);
      step(1, 1, 1, 0);
      check("tp3_nwords", int'(bus.n_words), 16);
      repeat (17) step(0, 0, 1, 0);

      // rd_en held longer than contents
      repeat (2) step(1, 1, 0, 0);
      repeat (4) step(0, 0, 1, 0);

      // reset mid-stream with a read in flight
      repeat (8) step(1, 1, 0, 0);
      repeat (3) step(0, 0, 1, 0);
      do_reset();
      step(1, 1, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      // drop-count saturation and clear coinciding with a drop
      repeat (16) step(1, 1, 0, 0);
      repeat (NMAX + 10) step(1, 1, 0, 0);
      check("tp6_sat", int'(bus.n_dropped), NMAX);
      step(1, 1, 0, 1);
      check("tp6_clrdrop", int'(bus.n_dropped), 1);
      step(0, 0, 0, 1);
      repeat (16) step(0, 0, 1, 0);

      // random traffic with alternating fill/drain bias
      for (int i = 0; i < 1500; i++) begin
         int  pp;
         bit  u;
         bit  v;
         bit  r;
         bit  c;
         pp = ((i % 300) < 150) ? 70 : 30;
         u  = ($urandom_range(0, 99) < pp);
         v  = ($urandom_range(0, 9) != 0);
         r  = ($urandom_range(0, 99) < (100 - pp));
         c  = ($urandom_range(0, 19) == 0);
         step(u, v, r, c);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
